pipe_skid_reg: RTL
==================

// Module: pipe_skid_reg
// PURPOSE
//  Parametrised pipeline stage register. It is the successor to the fixed
//  IF_ID/ID_EX/EX_MEM/MEM_WB-style stages.
//  Adds a valid/ready handshake, a 2-entry skid buffer for full throughput
//  with a registered in_ready, synchronous flush (branch squash), and a
//  saturating stall counter. Sits between any two processor pipe stages.
// PARAMETERS
//  WIDTH    16       payload width in bits (>=1)
//  RST_VAL  0        payload value loaded on reset and on flush (WIDTH bits)
//  STALL_W  8        stall counter width in bits (>=1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-high
//  flush      in   1        synchronous squash of all held entries
//  in_valid   in   1        upstream payload valid
//  in_ready   out  1        stage accepts payload (registered)
//  in_data    in   WIDTH    upstream payload
//  out_valid  out  1        downstream payload valid
//  out_ready  in   1        downstream accepts payload
//  out_data   out  WIDTH    downstream payload (main register)
//  stall_cnt  out  STALL_W  cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  Handshakes: acc_in = in_valid & in_ready; acc_out = out_valid & out_ready.
//  Reset (async, immediate): state=EMPTY, main=skid=RST_VAL, out_valid=0,
//   in_ready=1, out_data=RST_VAL, stall_cnt=0.
//  out_valid = (state!=EMPTY); out_data = main; in_ready = (state!=FULL),
//   taken from a flop, not from out_ready combinationally.
//  FSM, evaluated at the clk edge when flush=0:
//   EMPTY: acc_in -> BUSY, main<=in_data.
//   BUSY : acc_in&acc_out -> BUSY, main<=in_data.
//          acc_in only -> FULL, skid<=in_data.
//          acc_out only -> EMPTY.
//          neither -> hold.
//   FULL : acc_out -> BUSY, main<=skid. Otherwise hold. No acc_in possible.
//  Latency 1 cycle in->out. Sustained throughput 1 beat/clk with out_ready=1.
//  Ordering is strictly FIFO: the skid entry always leaves after main.
//  Stability: while out_valid & !out_ready, out_data is unchanged next cycle.
//  flush=1 at an edge:
//   - Overrides everything: state<=EMPTY, main<=skid<=RST_VAL, in_ready<=1.
//   - in_data presented that cycle is dropped even if in_valid=1 and in_ready=1.
//   - An acc_out in the same cycle still counts as delivered.
//  stall_cnt: +1 each edge where out_valid & !out_ready. Holds at 2^STALL_W-1.
//   Unaffected by flush; cleared only by rst.
//  rst mid-transfer: all entries are lost and outputs take reset values at once.
//  Back-to-back flush cycles keep the stage EMPTY.
// TESTING
//  1 Reset: assert rst mid-stream -> out_valid=0, in_ready=1,
//    out_data=RST_VAL, stall_cnt=0, all without a clock edge.
//  2 Streaming: out_ready=1, push A1..A8 on consecutive clks -> A1..A8
//    appear 1 clk later, one per clk, in_ready stays 1.
//  3 Skid: BUSY with B1, out_ready=0, push B2 -> state FULL, in_ready=0 the
//    next clk. Then out_ready=1 -> B1 then B2 on consecutive clks.
//  4 Flush: FULL with C1,C2, pulse flush with in_valid=1/C3 -> out_valid=0
//    next clk, C1..C3 never appear, out_data=RST_VAL, in_ready=1.
//  5 Stall counter: STALL_W=3, hold a valid beat with out_ready=0 for 10
//    clks -> stall_cnt reads 1..7 then holds at 7. Flush leaves it at 7.
//  6 Random in_valid/out_ready for 10k clks against a scoreboard FIFO ->
//    no loss, no duplication, order kept, out_data stable under stall.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating stall counter. in_ready comes from a flop.
module pipe_skid_reg #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               acc_in, acc_out;

    assign acc_in  = in_valid & in_ready_q;
    assign acc_out = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (acc_in) begin
                    state_d = BUSY;
                    main_d  = in_data;
                end
            end
            BUSY: begin
                if (acc_in && acc_out) begin
                    main_d = in_data;
                end else if (acc_in) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (acc_out) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a drain can happen
                if (acc_out) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // Counts every edge with a held beat; flush does not clear it
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && (stall_q != '1))
            stall_d = stall_q + STALL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= RST_VAL;
            skid_q      <= RST_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign stall_cnt = stall_q;

endmodule
